fetch_unit: RTL and testbench

Parametrised instruction fetch stage sitting between the program counter logic and `decoder_stage`, replacing the single-register fetch. Generates sequential word addresses to a synchronous instruction memory, buffers returned instructions with their PC in a small FIFO, and presents them to decode through a valid/ready handshake. Supports branch redirect with flush and back-pressure from decode in place of the old stall enable.

---
 rtl/tinker_pkg.sv | 11 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// Shared defaults for the tinker pipeline (fetch_unit, instr_mem, decoder_stage).
//   ADDR_W   : instruction word-address width
//   INSTR_W  : instruction width
//   RESET_PC : fetch address loaded on reset
package tinker_pkg;

   localparam int ADDR_W   = 9;
   localparam int INSTR_W  = 32;
   localparam int RESET_PC = 0;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : synchronous flush (drops all entries)
//   push/wdata : write an entry (caller guarantees not full)
//   pop        : drop the head entry (caller guarantees not empty)
//   rdata      : head entry, valid while !empty
//   count, empty, full : occupancy
module sync_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been pushed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word reads to a synchronous
// instruction memory, buffers {pc, instr} in a FIFO and hands them to decode
// over valid/ready. A redirect flushes everything and restarts at a new PC.
//   clk, rst_n           : clock, synchronous active-low reset
//   redirect_valid/addr  : taken branch/jump, restart fetch at redirect_addr
//   imem_req/addr/rdata  : memory port, rdata returns one cycle after req
//   out_valid/ready      : handshake to decode
//   out_instr, out_pc    : FIFO head entry
module fetch_unit #(
   parameter int          ADDR_W   = tinker_pkg::ADDR_W,
   parameter int          INSTR_W  = tinker_pkg::INSTR_W,
   parameter int          DEPTH    = 4,
   parameter int unsigned RESET_PC = tinker_pkg::RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              inflight_q, inflight_d;

   logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [PTR_W:0]    fifo_count;
   logic [ENT_W-1:0]  fifo_rdata;
   logic              credit_ok;

   always_comb begin
      // Every issued request reserves a FIFO slot, so the response can
      // always be pushed without checking for space.
      credit_ok = !fifo_full && ((32'(fifo_count) + 32'(inflight_q)) < 32'(DEPTH));

      // rst_n gating keeps both handshakes quiet during the reset cycle,
      // even if the registers still hold pre-reset contents.
      imem_req  = rst_n && !redirect_valid && credit_ok;
      imem_addr = pc_q;
      out_valid = rst_n && !redirect_valid && !fifo_empty;

      fifo_push = inflight_q && !redirect_valid;
      fifo_pop  = out_valid && out_ready;

      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = 1'b0;
      if (redirect_valid) begin
         pc_d = redirect_addr;
      end else if (imem_req) begin
         pc_d          = pc_q + 1'b1;
         inflight_pc_d = pc_q;
         inflight_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= ADDR_W'(RESET_PC);
         inflight_pc_q <= '0;
         inflight_q    <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
      end
   end

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (redirect_valid),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({inflight_pc_q, imem_rdata}),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign out_pc    = fifo_rdata[ENT_W-1 -: ADDR_W];
   assign out_instr = fifo_rdata[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int AW = tinker_pkg::ADDR_W;
   localparam int IW = tinker_pkg::INSTR_W;
   localparam int RPC = tinker_pkg::RESET_PC;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, redirect_valid, out_ready;
   logic [AW-1:0] redirect_addr;

   logic          req4, req2, v4, v2;
   logic [AW-1:0] addr4, addr2, pc4, pc2;
   logic [IW-1:0] rd4, rd2, ins4, ins2;

   logic [IW-1:0] mem [0:(1<<AW)-1];

   always @(posedge clk) begin
      rd4 <= mem[addr4];
      rd2 <= mem[addr2];
   end

   fetch_unit #(.DEPTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .imem_req(req4), .imem_addr(addr4), .imem_rdata(rd4),
      .out_valid(v4), .out_ready(out_ready), .out_instr(ins4), .out_pc(pc4)
   );

   fetch_unit #(.DEPTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .imem_req(req2), .imem_addr(addr2), .imem_rdata(rd2),
      .out_valid(v2), .out_ready(out_ready), .out_instr(ins2), .out_pc(pc2)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: per instance, next PC, a list of buffered PCs
   // (instruction = mem[pc]) and an outstanding-request flag with its PC.
   int            dep [2] = '{4, 2};
   logic [AW-1:0] m_pc  [2];
   logic [AW-1:0] m_ipc [2];
   bit            m_infl[2];
   int            m_n   [2];
   logic [AW-1:0] m_q   [2][8];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_cycle(input bit r, input bit rv, input logic [AW-1:0] ra, input bit rdy);
      bit            ereq, evalid;
      logic          o_req, o_v;
      logic [AW-1:0] o_addr, o_pc;
      logic [IW-1:0] o_ins;
      logic [AW-1:0] head;
      rst_n          = r;
      redirect_valid = rv;
      redirect_addr  = ra;
      out_ready      = rdy;
      #1;
      for (int i = 0; i < 2; i++) begin
         o_req  = (i == 0) ? req4  : req2;
         o_addr = (i == 0) ? addr4 : addr2;
         o_v    = (i == 0) ? v4    : v2;
         o_pc   = (i == 0) ? pc4   : pc2;
         o_ins  = (i == 0) ? ins4  : ins2;
         ereq   = r && !rv && ((m_n[i] + int'(m_infl[i])) < dep[i]);
         evalid = r && !rv && (m_n[i] > 0);
         head   = m_q[i][0];
         chk((i == 0) ? "req_d4" : "req_d2", 64'(o_req), 64'(ereq));
         chk((i == 0) ? "valid_d4" : "valid_d2", 64'(o_v), 64'(evalid));
         if (ereq)
            chk((i == 0) ? "addr_d4" : "addr_d2", 64'(o_addr), 64'(m_pc[i]));
         if (evalid) begin
            chk((i == 0) ? "pc_d4" : "pc_d2", 64'(o_pc), 64'(head));
            chk((i == 0) ? "instr_d4" : "instr_d2", 64'(o_ins), 64'(mem[head]));
         end
         if (!r) begin
            m_pc[i]   = AW'(RPC);
            m_n[i]    = 0;
            m_infl[i] = 0;
         end else if (rv) begin
            m_pc[i]   = ra;
            m_n[i]    = 0;
            m_infl[i] = 0;
         end else begin
            if (evalid && rdy) begin
               for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k+1];
               m_n[i]--;
            end
            if (m_infl[i]) begin
               m_q[i][m_n[i]] = m_ipc[i];
               m_n[i]++;
            end
            if (ereq) begin
               m_ipc[i] = m_pc[i];
               m_pc[i]  = m_pc[i] + 1'b1;
            end
            m_infl[i] = ereq;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int a = 0; a < (1 << AW); a++) mem[a] = $urandom;
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b1;
      @(negedge clk);

      // reset, then streaming with decode always ready
      run_cycle(0, 0, '0, 1);
      run_cycle(0, 0, '0, 1);
      for (int c = 0; c < 10; c++) run_cycle(1, 0, '0, 1);

      // stall until full, then drain
      for (int c = 0; c < 8; c++) run_cycle(1, 0, '0, 0);
      for (int c = 0; c < 8; c++) run_cycle(1, 0, '0, 1);

      // redirect to 0x40 with 2 buffered + 1 in flight (depth 4)
      run_cycle(0, 0, '0, 0);
      for (int c = 0; c < 3; c++) run_cycle(1, 0, '0, 0);
      run_cycle(1, 1, AW'(9'h040), 0);
      for (int c = 0; c < 8; c++) run_cycle(1, 0, '0, 1);

      // PC wrap
      run_cycle(1, 1, AW'(9'h1FE), 1);
      for (int c = 0; c < 8; c++) run_cycle(1, 0, '0, 1);

      // back-to-back redirects, last one wins
      run_cycle(1, 1, AW'(9'h100), 1);
      run_cycle(1, 1, AW'(9'h120), 1);
      for (int c = 0; c < 6; c++) run_cycle(1, 0, '0, 1);

      // one-cycle reset with a full FIFO
      for (int c = 0; c < 8; c++) run_cycle(1, 0, '0, 0);
      run_cycle(0, 0, '0, 1);
      for (int c = 0; c < 8; c++) run_cycle(1, 0, '0, 1);

      // randomized traffic
      for (int c = 0; c < 500; c++) begin
         run_cycle(($urandom_range(99) != 0), ($urandom_range(15) == 0),
                   AW'($urandom), ($urandom_range(3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
